// File: rtl/serialtx_if.sv
// Software-facing byte-write and status bundle of the serial transmitter.
// The master side writes bytes and enables the link; the slave side reports line and status flags.
interface serialtx_if;
    logic       ena;
    logic       wren;
    logic [7:0] din;
    logic       tx;
    logic       tbnf;
    logic       tf;
    logic       txi;
    logic       txor;

    modport master (
        output ena, wren, din,
        input  tx, tbnf, tf, txi, txor
    );

    modport slave (
        input  ena, wren, din,
        output tx, tbnf, tf, txi, txor
    );
endinterface

// File: rtl/serialtx.sv
// Framed serial transmitter: buffers bytes in a small FIFO, sends start/8 data LSB-first/stop,
// and closes each packet with a CRC-8 frame once the FIFO drains.
module serialtx #(
    parameter int         CLKS_PER_BIT = 16,
    parameter int         FIFO_DEPTH   = 4,
    parameter logic [7:0] CRC_POLY     = 8'h07
) (
    input  logic      clk,
    input  logic      reset,
    serialtx_if.slave bus
);
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t            r_state;
    state_t            w_stateNext;
    logic [BAUD_W-1:0] r_baud;
    logic [BAUD_W-1:0] w_baudNext;
    logic [2:0]        r_bitIdx;
    logic [2:0]        w_bitIdxNext;
    logic [7:0]        r_shift;
    logic [7:0]        w_shiftNext;
    logic              r_isCrc;
    logic              w_isCrcNext;
    logic [7:0]        r_crc;
    logic [7:0]        w_crcNext;

    logic [7:0]        r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wrPtr;
    logic [PTR_W-1:0]  r_rdPtr;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  w_countNext;

    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_drop;
    logic              w_pop;
    logic [7:0]        w_head;
    logic              w_txNext;
    logic              w_txiNext;

    logic              r_tx;
    logic              r_tbnf;
    logic              r_tf;
    logic              r_txi;
    logic              r_txor;

    // Whole-byte CRC-8 step (MSB-first, no reflection), applied once per popped byte.
    function automatic logic [7:0] crcByte(input logic [7:0] crcIn, input logic [7:0] data);
        logic [7:0] c;
        c = crcIn ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ CRC_POLY) : (c << 1);
        end
        return c;
    endfunction

    // Fullness uses the pre-edge count, so a same-cycle pop never makes room for a write.
    assign w_full  = (r_count == CNT_FULL);
    assign w_empty = (r_count == '0);
    assign w_push  = bus.ena & bus.wren & ~w_full;
    assign w_drop  = bus.ena & bus.wren & w_full;
    assign w_head  = r_mem[r_rdPtr];

    always_comb begin
        w_countNext = r_count;
        if (!bus.ena) begin
            w_countNext = '0;
        end else if (w_push && !w_pop) begin
            w_countNext = r_count + CNT_ONE;
        end else if (!w_push && w_pop) begin
            w_countNext = r_count - CNT_ONE;
        end
    end

    always_comb begin
        w_stateNext  = r_state;
        w_baudNext   = r_baud;
        w_bitIdxNext = r_bitIdx;
        w_shiftNext  = r_shift;
        w_isCrcNext  = r_isCrc;
        w_crcNext    = r_crc;
        w_pop        = 1'b0;
        w_txiNext    = 1'b0;

        if (!bus.ena) begin
            w_stateNext  = IDLE;
            w_baudNext   = '0;
            w_bitIdxNext = '0;
            w_isCrcNext  = 1'b0;
            w_crcNext    = '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_shiftNext = w_head;
                        w_crcNext   = crcByte(r_crc, w_head);
                        w_isCrcNext = 1'b0;
                        w_baudNext  = '0;
                        w_stateNext = START;
                    end
                end
                START: begin
                    if (r_baud == BAUD_LAST) begin
                        w_baudNext   = '0;
                        w_bitIdxNext = '0;
                        w_stateNext  = DATA;
                    end else begin
                        w_baudNext = r_baud + BAUD_ONE;
                    end
                end
                DATA: begin
                    if (r_baud == BAUD_LAST) begin
                        w_baudNext = '0;
                        if (r_bitIdx == 3'd7) begin
                            w_stateNext = STOP;
                        end else begin
                            w_bitIdxNext = r_bitIdx + 3'd1;
                            w_shiftNext  = {1'b0, r_shift[7:1]};
                        end
                    end else begin
                        w_baudNext = r_baud + BAUD_ONE;
                    end
                end
                STOP: begin
                    if (r_baud != BAUD_LAST) begin
                        w_baudNext = r_baud + BAUD_ONE;
                    end else begin
                        w_baudNext = '0;
                        // Back-to-back frames: the next byte (or the CRC) starts with no idle gap.
                        if (r_isCrc) begin
                            w_stateNext = IDLE;
                            w_isCrcNext = 1'b0;
                            w_crcNext   = '0;
                            w_txiNext   = 1'b1;
                        end else if (!w_empty) begin
                            w_pop       = 1'b1;
                            w_shiftNext = w_head;
                            w_crcNext   = crcByte(r_crc, w_head);
                            w_stateNext = START;
                        end else begin
                            w_shiftNext = r_crc;
                            w_isCrcNext = 1'b1;
                            w_stateNext = START;
                        end
                    end
                end
                default: begin
                    w_stateNext = IDLE;
                end
            endcase
        end
    end

    // The line level is registered from the state being entered, so tx follows the FSM edge-for-edge.
    always_comb begin
        w_txNext = 1'b1;
        unique case (w_stateNext)
            START:   w_txNext = 1'b0;
            DATA:    w_txNext = w_shiftNext[0];
            default: w_txNext = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_baud   <= '0;
            r_bitIdx <= '0;
            r_shift  <= '0;
            r_isCrc  <= 1'b0;
            r_crc    <= '0;
            r_tx     <= 1'b1;
            r_tbnf   <= 1'b1;
            r_tf     <= 1'b1;
            r_txi    <= 1'b0;
            r_txor   <= 1'b0;
        end else begin
            r_state  <= w_stateNext;
            r_baud   <= w_baudNext;
            r_bitIdx <= w_bitIdxNext;
            r_shift  <= w_shiftNext;
            r_isCrc  <= w_isCrcNext;
            r_crc    <= w_crcNext;
            r_tx     <= w_txNext;
            r_tbnf   <= (w_countNext != CNT_FULL);
            r_tf     <= (w_stateNext == IDLE) && (w_countNext == '0);
            r_txi    <= w_txiNext;
            r_txor   <= w_drop;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            r_count <= w_countNext;
            if (!bus.ena) begin
                r_wrPtr <= '0;
                r_rdPtr <= '0;
            end else begin
                if (w_push) begin
                    r_wrPtr <= r_wrPtr + PTR_ONE;
                end
                if (w_pop) begin
                    r_rdPtr <= r_rdPtr + PTR_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= bus.din;
        end
    end

    assign bus.tx   = r_tx;
    assign bus.tbnf = r_tbnf;
    assign bus.tf   = r_tf;
    assign bus.txi  = r_txi;
    assign bus.txor = r_txor;
endmodule
